// File: rtl/uart_rx_ctrl_if.sv
// Host/receive-core bundle for uart_rx_ctrl.
// err_cnt is present only when UART_RX_ERR_CNT_EN is defined.
interface uart_rx_ctrl_if;
    logic       cfg_wr;
    logic [5:0] cfg_prescale;
    logic       cfg_par_en;
    logic       cfg_par_typ;
    logic       rx_busy;
    logic       rx_valid;
    logic [7:0] rx_data;
    logic       rx_par_err;
    logic       rx_stp_err;
    logic       rx_enable;
    logic [5:0] prescale;
    logic       par_en;
    logic       par_typ;
    logic       cfg_pending;
    logic       host_rd;
    logic [7:0] host_data;
    logic [1:0] host_err;
    logic       host_empty;
    logic [2:0] fifo_cnt;
    logic       overrun;
    logic       ovr_clr;
`ifdef UART_RX_ERR_CNT_EN
    logic [7:0] err_cnt;
`endif

    modport slave (
        input  cfg_wr, cfg_prescale, cfg_par_en, cfg_par_typ,
        input  rx_busy, rx_valid, rx_data, rx_par_err, rx_stp_err,
        input  host_rd, ovr_clr,
        output rx_enable, prescale, par_en, par_typ, cfg_pending,
        output host_data, host_err, host_empty, fifo_cnt, overrun
`ifdef UART_RX_ERR_CNT_EN
        , output err_cnt
`endif
    );

    modport master (
        output cfg_wr, cfg_prescale, cfg_par_en, cfg_par_typ,
        output rx_busy, rx_valid, rx_data, rx_par_err, rx_stp_err,
        output host_rd, ovr_clr,
        input  rx_enable, prescale, par_en, par_typ, cfg_pending,
        input  host_data, host_err, host_empty, fifo_cnt, overrun
`ifdef UART_RX_ERR_CNT_EN
        , input err_cnt
`endif
    );
endinterface

// File: rtl/uart_rx_ctrl.sv
// UART receive controller: safe shadow-configuration hand-over plus 4-entry FWFT frame FIFO.
// Optional feature macro: UART_RX_ERR_CNT_EN adds a saturating error-frame counter (err_cnt).
module uart_rx_ctrl (
    input logic          clk,
    input logic          RST,
    uart_rx_ctrl_if.slave bus
);
    typedef enum logic [1:0] {
        OFF   = 2'd0,
        RUN   = 2'd1,
        DRAIN = 2'd2,
        APPLY = 2'd3
    } state_e;

    state_e     state_q, state_d;
    logic [5:0] shd_pre_q, shd_pre_d;
    logic       shd_pen_q, shd_pen_d;
    logic       shd_pty_q, shd_pty_d;
    logic [5:0] pre_q, pre_d;
    logic       pen_q, pen_d;
    logic       pty_q, pty_d;
    logic       pend_q, pend_d;
    logic       rx_en_q, rx_en_d;
    logic       cfg_ok_s;

    logic [9:0] mem_q [4];
    logic [1:0] wptr_q, rptr_q;
    logic [2:0] cnt_q, cnt_d;
    logic       ovr_q;
    logic       push_s, pop_s, full_s, wr_s, ovr_set_s;

    assign cfg_ok_s = bus.cfg_wr && ((bus.cfg_prescale == 6'd8) ||
                      (bus.cfg_prescale == 6'd16) || (bus.cfg_prescale == 6'd32));

    // Next-state, shadow capture and active-configuration hand-over.
    always_comb begin
        state_d   = state_q;
        shd_pre_d = shd_pre_q;
        shd_pen_d = shd_pen_q;
        shd_pty_d = shd_pty_q;
        pre_d     = pre_q;
        pen_d     = pen_q;
        pty_d     = pty_q;
        pend_d    = pend_q;
        if (cfg_ok_s) begin
            shd_pre_d = bus.cfg_prescale;
            shd_pen_d = bus.cfg_par_en;
            shd_pty_d = bus.cfg_par_typ;
        end else begin
            shd_pre_d = shd_pre_q;
        end
        case (state_q)
            OFF: begin
                if (pend_q && !bus.rx_busy) state_d = APPLY;
                else                        state_d = OFF;
            end
            RUN: begin
                if (pend_q) state_d = bus.rx_busy ? DRAIN : APPLY;
                else        state_d = RUN;
            end
            DRAIN: begin
                if (bus.rx_busy) state_d = DRAIN;
                else             state_d = APPLY;
            end
            APPLY: begin
                // A frame that started on the RUN->APPLY edge must not see settings change under it.
                if (bus.rx_busy || cfg_ok_s) state_d = DRAIN;
                else                         state_d = RUN;
                if (!bus.rx_busy) begin
                    pre_d  = shd_pre_q;
                    pen_d  = shd_pen_q;
                    pty_d  = shd_pty_q;
                    pend_d = 1'b0;
                end else begin
                    pend_d = pend_q;
                end
            end
            default: state_d = OFF;
        endcase
        if (cfg_ok_s) pend_d = 1'b1;
        else          pend_d = pend_d;
        rx_en_d = (state_d == RUN) || (state_d == DRAIN);
    end

    // Controller state, shadow and active configuration registers.
    always_ff @(posedge clk or negedge RST) begin
        if (!RST) begin
            state_q   <= OFF;
            shd_pre_q <= 6'd8;
            shd_pen_q <= 1'b0;
            shd_pty_q <= 1'b0;
            pre_q     <= 6'd8;
            pen_q     <= 1'b0;
            pty_q     <= 1'b0;
            pend_q    <= 1'b0;
            rx_en_q   <= 1'b0;
        end else begin
            state_q   <= state_d;
            shd_pre_q <= shd_pre_d;
            shd_pen_q <= shd_pen_d;
            shd_pty_q <= shd_pty_d;
            pre_q     <= pre_d;
            pen_q     <= pen_d;
            pty_q     <= pty_d;
            pend_q    <= pend_d;
            rx_en_q   <= rx_en_d;
        end
    end

    assign push_s    = bus.rx_valid && rx_en_q;
    assign pop_s     = bus.host_rd && (cnt_q != 3'd0);
    assign full_s    = (cnt_q == 3'd4);
    assign wr_s      = push_s && (!full_s || pop_s);
    assign ovr_set_s = push_s && full_s && !pop_s;

    // Occupancy update; a write and a pop in the same cycle cancel out.
    always_comb begin
        cnt_d = cnt_q;
        case ({wr_s, pop_s})
            2'b10:   cnt_d = cnt_q + 3'd1;
            2'b01:   cnt_d = cnt_q - 3'd1;
            default: cnt_d = cnt_q;
        endcase
    end

    // FIFO storage; contents are don't-care until written, head is masked when empty.
    always_ff @(posedge clk) begin
        if (wr_s) mem_q[wptr_q] <= {bus.rx_stp_err, bus.rx_par_err, bus.rx_data};
    end

    // FIFO pointers, occupancy and sticky overrun.
    always_ff @(posedge clk or negedge RST) begin
        if (!RST) begin
            wptr_q <= 2'd0;
            rptr_q <= 2'd0;
            cnt_q  <= 3'd0;
            ovr_q  <= 1'b0;
        end else begin
            if (wr_s)  wptr_q <= wptr_q + 2'd1;
            if (pop_s) rptr_q <= rptr_q + 2'd1;
            cnt_q <= cnt_d;
            if (ovr_set_s)        ovr_q <= 1'b1;
            else if (bus.ovr_clr) ovr_q <= 1'b0;
        end
    end

`ifdef UART_RX_ERR_CNT_EN
    logic [7:0] err_cnt_q;

    // Saturating count of accepted frames carrying a parity or stop error.
    always_ff @(posedge clk or negedge RST) begin
        if (!RST) begin
            err_cnt_q <= 8'd0;
        end else if (bus.ovr_clr) begin
            err_cnt_q <= 8'd0;
        end else if (push_s && (bus.rx_par_err || bus.rx_stp_err) && (err_cnt_q != 8'hFF)) begin
            err_cnt_q <= err_cnt_q + 8'd1;
        end
    end

    assign bus.err_cnt = err_cnt_q;
`endif

    assign bus.rx_enable   = rx_en_q;
    assign bus.prescale    = pre_q;
    assign bus.par_en      = pen_q;
    assign bus.par_typ     = pty_q;
    assign bus.cfg_pending = pend_q;
    assign bus.host_empty  = (cnt_q == 3'd0);
    assign bus.fifo_cnt    = cnt_q;
    assign bus.overrun     = ovr_q;
    assign bus.host_data   = (cnt_q == 3'd0) ? 8'd0 : mem_q[rptr_q][7:0];
    assign bus.host_err    = (cnt_q == 3'd0) ? 2'd0 : mem_q[rptr_q][9:8];
endmodule

// File: tb/tb_uart_rx_ctrl.sv
// Directed bench for uart_rx_ctrl: configuration hand-over, FIFO order/overrun, reset.
module tb_uart_rx_ctrl;
    logic clk;
    logic RST;
    int   checks;
    int   errors;

    uart_rx_ctrl_if bus_if ();

    uart_rx_ctrl dut (
        .clk (clk),
        .RST (RST),
        .bus (bus_if)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic push(input logic [7:0] d, input logic pe, input logic se);
        bus_if.rx_valid   = 1'b1;
        bus_if.rx_data    = d;
        bus_if.rx_par_err = pe;
        bus_if.rx_stp_err = se;
        tick();
        bus_if.rx_valid   = 1'b0;
        bus_if.rx_par_err = 1'b0;
        bus_if.rx_stp_err = 1'b0;
    endtask

    task automatic pop();
        bus_if.host_rd = 1'b1;
        tick();
        bus_if.host_rd = 1'b0;
    endtask

    task automatic cfg(input logic [5:0] p, input logic pe, input logic pt);
        bus_if.cfg_wr       = 1'b1;
        bus_if.cfg_prescale = p;
        bus_if.cfg_par_en   = pe;
        bus_if.cfg_par_typ  = pt;
        tick();
        bus_if.cfg_wr       = 1'b0;
    endtask

    logic [7:0] vals [5];
    logic [1:0] errs [4];

    initial begin
        checks = 0;
        errors = 0;
        vals[0] = 8'h11; vals[1] = 8'h22; vals[2] = 8'h33; vals[3] = 8'h44; vals[4] = 8'h55;
        errs[0] = 2'b00; errs[1] = 2'b01; errs[2] = 2'b10; errs[3] = 2'b00;
        RST = 1'b0;
        bus_if.cfg_wr = 1'b0; bus_if.cfg_prescale = 6'd0; bus_if.cfg_par_en = 1'b0;
        bus_if.cfg_par_typ = 1'b0; bus_if.rx_busy = 1'b0; bus_if.rx_valid = 1'b0;
        bus_if.rx_data = 8'd0; bus_if.rx_par_err = 1'b0; bus_if.rx_stp_err = 1'b0;
        bus_if.host_rd = 1'b0; bus_if.ovr_clr = 1'b0;
        repeat (3) tick();

        chk("rst_rx_enable", 32'(bus_if.rx_enable), 32'd0);
        chk("rst_prescale", 32'(bus_if.prescale), 32'd8);
        chk("rst_par", 32'({bus_if.par_en, bus_if.par_typ}), 32'd0);
        chk("rst_pending", 32'(bus_if.cfg_pending), 32'd0);
        chk("rst_empty", 32'(bus_if.host_empty), 32'd1);
        chk("rst_cnt", 32'(bus_if.fifo_cnt), 32'd0);
        chk("rst_overrun", 32'(bus_if.overrun), 32'd0);
        chk("rst_head", 32'({bus_if.host_err, bus_if.host_data}), 32'd0);
`ifdef UART_RX_ERR_CNT_EN
        chk("rst_err_cnt", 32'(bus_if.err_cnt), 32'd0);
`endif
        RST = 1'b1;
        tick();

        // Frames while disabled are discarded.
        push(8'h77, 1'b0, 1'b0);
        chk("off_discard_cnt", 32'(bus_if.fifo_cnt), 32'd0);
        chk("off_discard_empty", 32'(bus_if.host_empty), 32'd1);

        // First configuration from OFF.
        cfg(6'd16, 1'b1, 1'b0);
        chk("cfg1_pending", 32'(bus_if.cfg_pending), 32'd1);
        chk("cfg1_pre_old", 32'(bus_if.prescale), 32'd8);
        tick();
        chk("apply_rx_enable", 32'(bus_if.rx_enable), 32'd0);
        chk("apply_pre_old", 32'(bus_if.prescale), 32'd8);
        tick();
        chk("run_prescale", 32'(bus_if.prescale), 32'd16);
        chk("run_par_en", 32'(bus_if.par_en), 32'd1);
        chk("run_pending", 32'(bus_if.cfg_pending), 32'd0);
        chk("run_rx_enable", 32'(bus_if.rx_enable), 32'd1);

        // Reconfigure mid-frame: held until rx_busy drops.
        bus_if.rx_busy = 1'b1;
        cfg(6'd32, 1'b1, 1'b1);
        chk("drain_pending", 32'(bus_if.cfg_pending), 32'd1);
        for (int i = 0; i < 19; i++) begin
            tick();
            chk("drain_hold_pre", 32'(bus_if.prescale), 32'd16);
            chk("drain_rx_enable", 32'(bus_if.rx_enable), 32'd1);
        end
        bus_if.rx_busy = 1'b0;
        tick();
        chk("drain_apply_en", 32'(bus_if.rx_enable), 32'd0);
        chk("drain_apply_pre", 32'(bus_if.prescale), 32'd16);
        tick();
        chk("drain_new_pre", 32'(bus_if.prescale), 32'd32);
        chk("drain_new_typ", 32'(bus_if.par_typ), 32'd1);
        chk("drain_run_en", 32'(bus_if.rx_enable), 32'd1);
        chk("drain_done_pend", 32'(bus_if.cfg_pending), 32'd0);

        // Illegal prescale is ignored.
        cfg(6'd12, 1'b0, 1'b0);
        chk("illegal_pending", 32'(bus_if.cfg_pending), 32'd0);
        chk("illegal_pre", 32'(bus_if.prescale), 32'd32);
        tick();
        chk("illegal_run", 32'(bus_if.rx_enable), 32'd1);
        chk("illegal_par", 32'({bus_if.par_en, bus_if.par_typ}), 32'd3);

        // Fill, overflow, then drain in order.
        for (int i = 0; i < 5; i++) begin
            push(vals[i], (i == 1), (i == 2));
            if (i == 0) chk("fifo_first_head", 32'(bus_if.host_data), 32'h11);
            if (i == 3) chk("fifo_full_ovr", 32'(bus_if.overrun), 32'd0);
        end
        chk("fifo_full_cnt", 32'(bus_if.fifo_cnt), 32'd4);
        chk("fifo_overrun", 32'(bus_if.overrun), 32'd1);
        for (int i = 0; i < 4; i++) begin
            chk("pop_data", 32'(bus_if.host_data), 32'(vals[i]));
            chk("pop_err", 32'(bus_if.host_err), 32'(errs[i]));
            pop();
        end
        chk("drained_empty", 32'(bus_if.host_empty), 32'd1);
        chk("drained_head", 32'({bus_if.host_err, bus_if.host_data}), 32'd0);
        pop();
        chk("pop_empty_cnt", 32'(bus_if.fifo_cnt), 32'd0);
        chk("ovr_sticky", 32'(bus_if.overrun), 32'd1);
        bus_if.ovr_clr = 1'b1;
        tick();
        bus_if.ovr_clr = 1'b0;
        chk("ovr_cleared", 32'(bus_if.overrun), 32'd0);

        // Full FIFO with simultaneous push and pop.
        push(8'hA1, 1'b0, 1'b0); push(8'hA2, 1'b0, 1'b0);
        push(8'hA3, 1'b0, 1'b0); push(8'hA4, 1'b0, 1'b0);
        bus_if.host_rd = 1'b1;
        push(8'h66, 1'b0, 1'b0);
        bus_if.host_rd = 1'b0;
        chk("pp_cnt", 32'(bus_if.fifo_cnt), 32'd4);
        chk("pp_overrun", 32'(bus_if.overrun), 32'd0);
        chk("pp_head", 32'(bus_if.host_data), 32'hA2);
        bus_if.ovr_clr = 1'b1;
        push(8'h99, 1'b0, 1'b0);
        bus_if.ovr_clr = 1'b0;
        chk("clr_vs_set", 32'(bus_if.overrun), 32'd1);
        chk("clr_vs_set_cnt", 32'(bus_if.fifo_cnt), 32'd4);
        pop(); pop(); pop();
        chk("pp_last", 32'(bus_if.host_data), 32'h66);
        pop();
        chk("pp_empty", 32'(bus_if.host_empty), 32'd1);

`ifdef UART_RX_ERR_CNT_EN
        bus_if.host_rd = 1'b1;
        for (int i = 0; i < 300; i++) push(8'(i), 1'b1, 1'b0);
        bus_if.host_rd = 1'b0;
        chk("err_cnt_sat", 32'(bus_if.err_cnt), 32'd255);
        bus_if.ovr_clr = 1'b1;
        tick();
        bus_if.ovr_clr = 1'b0;
        chk("err_cnt_clr", 32'(bus_if.err_cnt), 32'd0);
`endif

        // Asynchronous reset mid-operation.
        push(8'h5A, 1'b0, 1'b0);
        cfg(6'd8, 1'b0, 1'b0);
        chk("pre_rst_pending", 32'(bus_if.cfg_pending), 32'd1);
        #2;
        RST = 1'b0;
        #1;
        chk("async_rst_cnt", 32'(bus_if.fifo_cnt), 32'd0);
        chk("async_rst_empty", 32'(bus_if.host_empty), 32'd1);
        chk("async_rst_pending", 32'(bus_if.cfg_pending), 32'd0);
        chk("async_rst_pre", 32'(bus_if.prescale), 32'd8);
        chk("async_rst_en", 32'(bus_if.rx_enable), 32'd0);
        tick();
        RST = 1'b1;
        repeat (3) tick();
        chk("post_rst_off", 32'(bus_if.rx_enable), 32'd0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule
